// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: digit width,
// default parameter values and the digit-select helper.
package seg_pkg;

  localparam int SEG_DIGIT_W            = 4;
  localparam int SEG_MAX_DIGITS         = 8;
  localparam int SEG_NUM_DIGITS_DEF     = 6;
  localparam int SEG_CLK_DIV_DEF        = 50000;
  localparam bit SEG_SEL_ACTIVE_LOW_DEF = 1'b1;

  // One-hot select for digit idx, inverted when the common lines are active low.
  // Callers keep only the low NUM_DIGITS bits.
  function automatic logic [SEG_MAX_DIGITS-1:0] sel_onehot(input logic [2:0] idx,
                                                           input logic       active_low);
    logic [SEG_MAX_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Host-side bundle of the scanner: value/load/control in, digit nibble,
// digit select and pending flag out.
interface seg_scan_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = SEG_NUM_DIGITS_DEF
);

  logic [SEG_DIGIT_W*NUM_DIGITS-1:0] data_in;
  logic                              load;
  logic                              en;
  logic                              blank_lz;
  logic [SEG_DIGIT_W-1:0]            data_disp;
  logic [NUM_DIGITS-1:0]             sel;
  logic                              pending;

  modport master (
    output data_in, load, en, blank_lz,
    input  data_disp, sel, pending
  );

  modport slave (
    input  data_in, load, en, blank_lz,
    output data_disp, sel, pending
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]     CNT_LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt_q, div_cnt_d;

  // Next count: wrap to zero after the last slot cycle.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed digit scanner. New values are staged in pend and only
// committed to disp at a frame boundary, so a frame never mixes two values.
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = SEG_NUM_DIGITS_DEF,
  parameter int CLK_DIV        = SEG_CLK_DIV_DEF,
  parameter bit SEL_ACTIVE_LOW = SEG_SEL_ACTIVE_LOW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int                    IDX_W    = $clog2(NUM_DIGITS);
  localparam int                    DATA_W   = SEG_DIGIT_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? '1 : '0;

  logic                   tick;
  logic                   frame_end;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      disp_q, disp_d;
  logic [DATA_W-1:0]      pend_q, pend_d;
  logic                   pending_q, pending_d;
  logic [SEG_DIGIT_W-1:0] data_disp_q, data_disp_d;
  logic [NUM_DIGITS-1:0]  sel_q, sel_d;
  logic [SEG_DIGIT_W-1:0] nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  blank;
  logic [SEG_MAX_DIGITS-1:0] sel_full;

  tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_end = tick && (idx_q == IDX_LAST);

  // Per-digit nibble split and leading-zero detection (digit 0 is never blanked).
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = disp_q[gi*SEG_DIGIT_W +: SEG_DIGIT_W];
    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = bus.blank_lz && (disp_q[DATA_W-1:gi*SEG_DIGIT_W] == '0);
    end
  end

  // Digit index, load staging/commit and the next output values.
  always_comb begin
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pending_d   = pending_q;
    data_disp_d = nib[idx_q];
    sel_d       = SEL_IDLE;
    sel_full    = sel_onehot(3'(idx_q), SEL_ACTIVE_LOW);

    if (tick) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end

    // A load coinciding with the boundary bypasses pend and wins over it.
    if (bus.load && !frame_end) begin
      pend_d    = bus.data_in;
      pending_d = 1'b1;
    end else if (frame_end && bus.load) begin
      disp_d    = bus.data_in;
      pending_d = 1'b0;
    end else if (frame_end && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end

    if (bus.en && !blank[idx_q]) begin
      sel_d = sel_full[NUM_DIGITS-1:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pending_q   <= 1'b0;
      data_disp_q <= '0;
      sel_q       <= SEL_IDLE;
    end else begin
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pending_q   <= pending_d;
      data_disp_q <= data_disp_d;
      sel_q       <= sel_d;
    end
  end

  assign bus.data_disp = data_disp_q;
  assign bus.sel       = sel_q;
  assign bus.pending   = pending_q;

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed digit scanner that drives a multi-digit common-cathode 7-segment display. It holds a packed hex value, steps through the digits at a programmable refresh rate, and presents one nibble per step on `data_disp` together with a one-hot digit select `sel`. It sits directly upstream of `seg_decoder`: `data_disp` feeds `seg_decoder.data_disp`, and `sel` drives the digit common lines alongside the decoded segments. Display updates are tear-free because new data is committed only at frame boundaries.

## Interface
- `NUM_DIGITS`, default 6. Number of digits, range 2..8.
- `CLK_DIV`, default 50000. Clock cycles per digit slot, minimum 2.
- `SEL_ACTIVE_LOW`, default 1. When 1, the selected digit is driven 0 and all others 1.
- `clk`, input, 1 bit. Single clock; all state is updated on the rising edge.
- `rst`, input, 1 bit. Synchronous, active-high reset.
- `data_in`, input, 4*NUM_DIGITS bits. Packed hex value; digit 0 is `[3:0]` and is the least significant.
- `load`, input, 1 bit. Single-cycle strobe that captures `data_in`.
- `en`, input, 1 bit. When 0, all digits are dark; the counters keep running.
- `blank_lz`, input, 1 bit. When 1, leading zeros are suppressed.
- `data_disp`, output, 4 bits. Nibble for the currently selected digit; goes to `seg_decoder`.
- `sel`, output, NUM_DIGITS bits. One-hot digit select, with polarity set by `SEL_ACTIVE_LOW`.
- `pending`, output, 1 bit. High while captured data is waiting for the next frame boundary.

## Operation
- **Prescaler.** `div_cnt` counts 0..CLK_DIV-1 and then wraps. `tick` is asserted in the cycle where `div_cnt == CLK_DIV-1`.
- **Digit index.** `idx` counts 0..NUM_DIGITS-1 and advances on `tick`. `frame_end` = `tick` && `idx == NUM_DIGITS-1`; on `frame_end`, `idx` wraps to 0.
- **Load path.**
  - `load` && !`frame_end`: `pend_reg` <= `data_in` and `pending` <= 1.
  - `frame_end` && `pending` && !`load`: `disp_reg` <= `pend_reg` and `pending` <= 0.
  - `frame_end` && `load` (simultaneous): `disp_reg` <= `data_in` directly and `pending` <= 0. The new value wins over any older pending value.
  - Repeated `load` before a frame boundary overwrites `pend_reg`; only the last value is displayed.
- **Leading-zero blanking.** Digit k is blank when `blank_lz` = 1, k > 0, and every nibble from k through NUM_DIGITS-1 of `disp_reg` is 0. Digit 0 is never blanked by this rule.
- **Output register.** Updated every cycle:
  - `data_disp` <= nibble `idx` of `disp_reg`.
  - `sel` <= one-hot(`idx`) if `en` and the digit is not blank; otherwise all inactive.
  - Polarity is applied last, according to `SEL_ACTIVE_LOW`.
- **Width rules.** `div_cnt` is $clog2(CLK_DIV) bits wide. `idx` is $clog2(NUM_DIGITS) bits wide and never takes values ≥ NUM_DIGITS.

## Timing
- **Reset values.** `div_cnt`=0, `idx`=0, `disp_reg`=0, `pend_reg`=0, `pending`=0, `data_disp`=4'h0, `sel`=all inactive (all ones when `SEL_ACTIVE_LOW`).
- **First cycle after reset.** Reset is deasserted at edge E. At edge E+1 the outputs show digit 0: `sel`=one-hot(0) if `en`, and `data_disp`=0.
- **Output latency.** One cycle from an `idx` change to `sel`/`data_disp`. Each digit is held for exactly CLK_DIV cycles; a full frame is NUM_DIGITS*CLK_DIV cycles.
- **Load timing.**
  - `load` sampled at edge t: `pending`=1 after edge t.
  - `disp_reg` updates at the next `frame_end` edge, and the new data reaches the outputs one edge later, on digit 0.
  - Worst-case load-to-display latency is NUM_DIGITS*CLK_DIV+1 cycles.
- **Enable.** `en` deasserted takes effect on `sel` one cycle later; `data_disp` keeps tracking `idx`.
- **Reset mid-frame or mid-pending.** Everything returns to the reset values; a pending load is discarded.

## Structure
- **Shared package `seg_pkg`.**
  - Constant `SEG_DIGIT_W` = 4.
  - Function `sel_onehot(idx, active_low)`.
  - Default-parameter constants, shared with `seg_decoder` top-level wiring.
- **Sub-module `tick_gen`.** Parameter `DIV`, ports `clk`, `rst`, `tick`. Implements the prescaler; reused by other timed display blocks.
- **`seg_scan` top.** Contains the index counter, the load/commit registers, the blanking logic and the output register.

## Test plan
All scenarios use `NUM_DIGITS`=4, `CLK_DIV`=4, `SEL_ACTIVE_LOW`=1.
- **Reset.** `rst` held high for 3 cycles → `sel`=4'b1111, `data_disp`=0, `pending`=0. One cycle after release → `sel`=4'b1110. `sel` then steps through 1101, 1011, 0111 every 4 cycles, wrapping after 16.
- **Load/commit.** `load` with `data_in`=16'h1A2F mid-frame → `pending`=1, with the old value still shown until the frame wrap. After the wrap, digits 0..3 show F, 2, A, 1 and `pending`=0.
- **Simultaneous events.** `load` 16'h0003 followed by `load` 16'h0004 on the `frame_end` cycle → 4 is displayed, 3 never appears, and `pending`=0.
- **Blanking.** With `data_in`=16'h0050 and `blank_lz`=1, `sel` is active only for digits 0 and 1. With `blank_lz`=0, all 4 digits are active. With `data_in`=0 and `blank_lz`=1, only digit 0 is shown, as 0.
- **Enable.** Hold `en`=0 for one frame → `sel`=4'b1111 throughout while `idx` keeps advancing. Reassert `en` → the scan resumes at the correct phase.
- **Reset during pending.** `load` 16'hBEEF, then `rst` before the frame wrap → `pending`=0, `disp_reg`=0, and all digits show 0.
